// File: rtl/timestamped_register_scheduler_pkg.sv
// timestamp_pkg: shared timestamp types, edge sense and scheduler states
package timestamp_pkg;
    localparam int TS_WIDTH = 32;
    typedef logic [TS_WIDTH-1:0] time_t;
    typedef enum logic {POSEDGE, NEGEDGE} edge_sense_e;
    typedef enum logic {S_INIT, S_RUN} sched_state_e;
    localparam time_t TIME_ZERO = '0;
endpackage

// File: rtl/timestamped_register_scheduler_if.sv
// timestamped_register_scheduler_if: clock/data input streams and q output stream
interface timestamped_register_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TIME_WIDTH = 32
);
    logic                  clk_valid;
    logic                  clk_ready;
    logic [TIME_WIDTH-1:0] clk_time;
    logic                  clk_value;
    logic                  d_valid;
    logic                  d_ready;
    logic [TIME_WIDTH-1:0] d_time;
    logic [DATA_WIDTH-1:0] d_data;
    logic                  q_valid;
    logic                  q_ready;
    logic [TIME_WIDTH-1:0] q_time;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  order_error;
    modport master (
        output clk_valid, clk_time, clk_value, d_valid, d_time, d_data, q_ready,
        input  clk_ready, d_ready, q_valid, q_time, q_data, order_error
    );
    modport slave (
        input  clk_valid, clk_time, clk_value, d_valid, d_time, d_data, q_ready,
        output clk_ready, d_ready, q_valid, q_time, q_data, order_error
    );
endinterface

// File: rtl/timestamped_register_scheduler_token_head_select.sv
// token_head_select: picks the earlier of the two stream heads, clock wins ties
module token_head_select #(
    parameter int TIME_WIDTH = 32
) (
    input  logic [TIME_WIDTH-1:0] clk_time,
    input  logic [TIME_WIDTH-1:0] d_time,
    output logic                  sel_clk,
    output logic [TIME_WIDTH-1:0] sel_time
);
    assign sel_clk  = clk_time <= d_time;
    assign sel_time = sel_clk ? clk_time : d_time;
endmodule

// File: rtl/timestamped_register_scheduler.sv
// timestamped_register_scheduler: host-clocked model of one edge-triggered register on timestamped streams
module timestamped_register_scheduler
    import timestamp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    TIME_WIDTH = 32,
    parameter string                 EDGE_SENSE = "POSEDGE",
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic clock,
    input logic reset,
    timestamped_register_scheduler_if.slave bus
);
    localparam edge_sense_e SENSE = (EDGE_SENSE == "NEGEDGE") ? NEGEDGE : POSEDGE;
    sched_state_e          state;
    logic                  clk_level;
    logic [DATA_WIDTH-1:0] d_cur;
    logic [DATA_WIDTH-1:0] q_cur;
    logic [TIME_WIDTH-1:0] last_time;
    logic                  q_valid;
    logic [TIME_WIDTH-1:0] q_time;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  order_error;
    logic                  sel_clk;
    logic [TIME_WIDTH-1:0] sel_time;
    logic                  go;
    logic                  active;

    token_head_select #(.TIME_WIDTH(TIME_WIDTH)) u_head (
        .clk_time(bus.clk_time),
        .d_time  (bus.d_time),
        .sel_clk (sel_clk),
        .sel_time(sel_time)
    );

    // Only advance when both heads are known, so the earliest event is certain
    assign go            = state == S_RUN && bus.clk_valid && bus.d_valid && !(q_valid && !bus.q_ready);
    assign bus.clk_ready = go && sel_clk;
    assign bus.d_ready   = go && !sel_clk;
    assign active        = (SENSE == POSEDGE) ? (!clk_level && bus.clk_value) : (clk_level && !bus.clk_value);
    assign bus.q_valid     = q_valid;
    assign bus.q_time      = q_time;
    assign bus.q_data      = q_data;
    assign bus.order_error = order_error;

    // Init token emission, then one event per cycle with capture and order tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_INIT;
            clk_level   <= 1'b0;
            d_cur       <= INIT_VALUE;
            q_cur       <= INIT_VALUE;
            last_time   <= TIME_WIDTH'(TIME_ZERO);
            q_valid     <= 1'b0;
            q_time      <= TIME_WIDTH'(TIME_ZERO);
            q_data      <= INIT_VALUE;
            order_error <= 1'b0;
        end else if (state == S_INIT) begin
            q_valid <= 1'b1;
            if (q_valid && bus.q_ready) begin
                q_valid <= 1'b0;
                state   <= S_RUN;
            end
        end else begin
            if (q_valid && bus.q_ready) q_valid <= 1'b0;
            if (bus.clk_ready) begin
                clk_level <= bus.clk_value;
                if (active && d_cur != q_cur) begin
                    q_cur   <= d_cur;
                    q_valid <= 1'b1;
                    q_time  <= bus.clk_time;
                    q_data  <= d_cur;
                end
            end
            if (bus.d_ready) d_cur <= bus.d_data;
            if (go) begin
                if (sel_time < last_time) order_error <= 1'b1;
                last_time <= sel_time;
            end
        end
    end
endmodule

// File: tb/tb_timestamped_register_scheduler.sv
// tb_timestamped_register_scheduler: directed scoreboard bench for POSEDGE and NEGEDGE instances
module tb_timestamped_register_scheduler;
    typedef struct {
        logic [31:0] t;
        logic [7:0]  v;
    } tok_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    tok_t cq0[$], dq0[$], cq1[$], dq1[$], eq0[$], eq1[$];
    logic [32:0] log0[$], log1[$];

    timestamped_register_scheduler_if #(.DATA_WIDTH(8), .TIME_WIDTH(32)) p ();
    timestamped_register_scheduler_if #(.DATA_WIDTH(8), .TIME_WIDTH(32)) n ();

    timestamped_register_scheduler #(
        .DATA_WIDTH(8), .TIME_WIDTH(32), .EDGE_SENSE("POSEDGE"), .INIT_VALUE(8'h00)
    ) dut_p (.clock(clock), .reset(reset), .bus(p));

    timestamped_register_scheduler #(
        .DATA_WIDTH(8), .TIME_WIDTH(32), .EDGE_SENSE("NEGEDGE"), .INIT_VALUE(8'hA5)
    ) dut_n (.clock(clock), .reset(reset), .bus(n));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take(input int k, input logic [31:0] t, input logic [7:0] v);
        tok_t e;
        if (k == 0) begin
            chk("q0_expected", 64'(eq0.size() != 0), 1);
            if (eq0.size() == 0) return;
            e = eq0.pop_front();
        end else begin
            chk("q1_expected", 64'(eq1.size() != 0), 1);
            if (eq1.size() == 0) return;
            e = eq1.pop_front();
        end
        chk($sformatf("q%0d_time", k), t, e.t);
        chk($sformatf("q%0d_data", k), v, e.v);
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (i < 300 && (eq0.size() != 0 || eq1.size() != 0 || cq0.size() != 0 || cq1.size() != 0)) begin
            @(posedge clock);
            i++;
        end
        chk(tag, 64'(eq0.size() + eq1.size() + cq0.size() + cq1.size()), 0);
    endtask

    // Stream drivers and output monitor: sample at negedge, advance heads after posedge
    initial begin
        logic tc0, td0, tc1, td1;
        forever begin
            @(negedge clock);
            tc0 = p.clk_ready;
            td0 = p.d_ready;
            tc1 = n.clk_ready;
            td1 = n.d_ready;
            if (tc0) log0.push_back({1'b1, cq0[0].t});
            if (td0) log0.push_back({1'b0, dq0[0].t});
            if (tc1) log1.push_back({1'b1, cq1[0].t});
            if (td1) log1.push_back({1'b0, dq1[0].t});
            if (p.q_valid && p.q_ready) take(0, p.q_time, p.q_data);
            if (n.q_valid && n.q_ready) take(1, n.q_time, n.q_data);
            @(posedge clock);
            #1;
            if (tc0 && cq0.size() != 0) cq0.delete(0);
            if (td0 && dq0.size() != 0) dq0.delete(0);
            if (tc1 && cq1.size() != 0) cq1.delete(0);
            if (td1 && dq1.size() != 0) dq1.delete(0);
            p.clk_valid = cq0.size() != 0;
            p.d_valid   = dq0.size() != 0;
            n.clk_valid = cq1.size() != 0;
            n.d_valid   = dq1.size() != 0;
            if (cq0.size() != 0) begin p.clk_time = cq0[0].t; p.clk_value = cq0[0].v[0]; end
            if (dq0.size() != 0) begin p.d_time = dq0[0].t; p.d_data = dq0[0].v; end
            if (cq1.size() != 0) begin n.clk_time = cq1[0].t; n.clk_value = cq1[0].v[0]; end
            if (dq1.size() != 0) begin n.d_time = dq1[0].t; n.d_data = dq1[0].v; end
        end
    end

    initial begin
        logic [32:0] xl0[7];
        logic [32:0] xl1[4];
        int i;
        xl0 = '{{1'b0, 32'd10}, {1'b1, 32'd20}, {1'b1, 32'd25}, {1'b1, 32'd30},
                {1'b0, 32'd30}, {1'b1, 32'd40}, {1'b1, 32'd50}};
        xl1 = '{{1'b0, 32'd3}, {1'b1, 32'd5}, {1'b0, 32'd7}, {1'b1, 32'd10}};
        p.clk_valid = 0; p.clk_time = 0; p.clk_value = 0; p.d_valid = 0; p.d_time = 0; p.d_data = 0; p.q_ready = 1;
        n.clk_valid = 0; n.clk_time = 0; n.clk_value = 0; n.d_valid = 0; n.d_time = 0; n.d_data = 0; n.q_ready = 1;
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_q_valid", p.q_valid, 0);
        chk("rst_clk_ready", p.clk_ready, 0);
        chk("rst_d_ready", p.d_ready, 0);
        chk("rst_order_error", p.order_error, 0);
        chk("rst_q_time", p.q_time, 0);
        chk("rst_q_data_p", p.q_data, 8'h00);
        chk("rst_q_data_n", n.q_data, 8'hA5);
        eq0.push_back('{32'd0, 8'h00});
        eq1.push_back('{32'd0, 8'hA5});
        @(posedge clock);
        #2 reset = 1'b1;
        drain("init_token");
        repeat (5) @(negedge clock);
        chk("idle_q_valid_p", p.q_valid, 0);
        chk("idle_q_valid_n", n.q_valid, 0);

        // Capture, tie ordering and negedge capture
        log0.delete();
        log1.delete();
        dq0.push_back('{32'd10, 8'h5A});
        dq0.push_back('{32'd30, 8'h33});
        dq0.push_back('{32'd60, 8'h77});
        cq0.push_back('{32'd20, 8'h01});
        cq0.push_back('{32'd25, 8'h00});
        cq0.push_back('{32'd30, 8'h01});
        cq0.push_back('{32'd40, 8'h00});
        cq0.push_back('{32'd50, 8'h01});
        eq0.push_back('{32'd20, 8'h5A});
        eq0.push_back('{32'd50, 8'h33});
        dq1.push_back('{32'd3, 8'h01});
        dq1.push_back('{32'd7, 8'h02});
        dq1.push_back('{32'd20, 8'h02});
        cq1.push_back('{32'd5, 8'h01});
        cq1.push_back('{32'd10, 8'h00});
        eq1.push_back('{32'd10, 8'h02});
        drain("capture_drain");
        chk("log0_len", 64'(log0.size()), 7);
        for (int k = 0; k < 7; k++) chk($sformatf("log0_%0d", k), log0[k], xl0[k]);
        chk("log1_len", 64'(log1.size()), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("log1_%0d", k), log1[k], xl1[k]);

        // Backpressure on a pending token
        @(posedge clock);
        #2 p.q_ready = 1'b0;
        cq0.push_back('{32'd65, 8'h00});
        cq0.push_back('{32'd70, 8'h01});
        cq0.push_back('{32'd75, 8'h00});
        cq0.push_back('{32'd85, 8'h01});
        dq0.push_back('{32'd80, 8'h11});
        dq0.push_back('{32'd90, 8'h11});
        eq0.push_back('{32'd70, 8'h77});
        eq0.push_back('{32'd85, 8'h11});
        i = 0;
        while (i < 100 && !p.q_valid) begin
            @(negedge clock);
            i++;
        end
        chk("stall_token_seen", p.q_valid, 1);
        repeat (5) begin
            @(negedge clock);
            chk("stall_clk_ready", p.clk_ready, 0);
            chk("stall_d_ready", p.d_ready, 0);
            chk("stall_q_valid", p.q_valid, 1);
            chk("stall_q_time", p.q_time, 70);
            chk("stall_q_data", p.q_data, 8'h77);
        end
        @(posedge clock);
        #2 p.q_ready = 1'b1;
        drain("stall_drain");

        // Out-of-order timestamp, then reset mid-stream
        cq0.push_back('{32'd95, 8'h00});
        dq0.push_back('{32'd40, 8'h22});
        repeat (10) @(negedge clock);
        chk("order_error_set", p.order_error, 1);
        repeat (5) @(negedge clock);
        chk("order_error_sticky", p.order_error, 1);
        chk("order_error_n_clear", n.order_error, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        cq0.delete(); dq0.delete(); cq1.delete(); dq1.delete();
        #1;
        chk("rst2_order_error", p.order_error, 0);
        chk("rst2_q_valid", p.q_valid, 0);
        chk("rst2_q_time", p.q_time, 0);
        chk("rst2_clk_ready", p.clk_ready, 0);
        eq0.push_back('{32'd0, 8'h00});
        eq1.push_back('{32'd0, 8'hA5});
        @(posedge clock);
        #2 reset = 1'b1;
        drain("reinit_token");
        repeat (3) @(negedge clock);
        chk("reinit_order_error", p.order_error, 0);
        chk("reinit_idle", p.q_valid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
